// File: rtl/btb_assoc_param.sv
// Set-associative branch target buffer: combinational lookup, registered update
// with true LRU and saturating direction counters, and a one-set-per-cycle flush engine.
module btb_assoc_param #(
    parameter int NUM_SETS    = 8,
    parameter int WAYS        = 2,
    parameter int CTR_W       = 2,
    parameter int ALLOC_ON_NT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_pc,
    output logic        lookup_hit,
    output logic        lookup_taken,
    output logic [31:0] lookup_target,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_target,
    input  logic        update_taken,
    input  logic        flush_req,
    output logic        flush_busy
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int AGE_W = $clog2(WAYS);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WT   = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] CTR_WNT  = CTR_WT - CTR_W'(1);
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);
    localparam logic [AGE_W-1:0] AGE_LRU  = AGE_W'(WAYS - 1);

    typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

    logic             valid_q  [NUM_SETS][WAYS];
    logic             valid_d  [NUM_SETS][WAYS];
    logic [TAG_W-1:0] tag_q    [NUM_SETS][WAYS];
    logic [TAG_W-1:0] tag_d    [NUM_SETS][WAYS];
    logic [31:0]      target_q [NUM_SETS][WAYS];
    logic [31:0]      target_d [NUM_SETS][WAYS];
    logic [CTR_W-1:0] ctr_q    [NUM_SETS][WAYS];
    logic [CTR_W-1:0] ctr_d    [NUM_SETS][WAYS];
    logic [AGE_W-1:0] age_q    [NUM_SETS][WAYS];
    logic [AGE_W-1:0] age_d    [NUM_SETS][WAYS];

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             flush_busy_q, flush_busy_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit, has_inv, do_upd, do_touch;
    logic [AGE_W-1:0] hit_way, inv_way, lru_way, touch_way, touch_age;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};
    assign flush_busy     = flush_busy_q;

    always_comb begin
        lk_idx        = lookup_pc[IDX_W+1:2];
        lk_tag        = lookup_pc[31:IDX_W+2];
        lookup_hit    = 1'b0;
        lookup_taken  = 1'b0;
        lookup_target = '0;
        // descending scan so the lowest matching way wins
        if (!flush_busy_q) begin
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
                    lookup_hit    = 1'b1;
                    lookup_taken  = ctr_q[lk_idx][w][CTR_W-1];
                    lookup_target = target_q[lk_idx][w];
                end
            end
        end
    end

    always_comb begin
        up_idx  = update_pc[IDX_W+1:2];
        up_tag  = update_pc[31:IDX_W+2];
        up_hit  = 1'b0;
        has_inv = 1'b0;
        hit_way = '0;
        inv_way = '0;
        lru_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
                up_hit  = 1'b1;
                hit_way = AGE_W'(w);
            end
            if (!valid_q[up_idx][w]) begin
                has_inv = 1'b1;
                inv_way = AGE_W'(w);
            end
            if (age_q[up_idx][w] == AGE_LRU) lru_way = AGE_W'(w);
        end
    end

    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        ctr_d     = ctr_q;
        age_d     = age_q;
        state_d   = state_q;
        ptr_d     = ptr_q;
        do_touch  = 1'b0;
        touch_way = '0;
        touch_age = '0;
        do_upd    = update_valid && (state_q == ST_IDLE) && !flush_req;

        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d = ST_FLUSH;
                    ptr_d   = '0;
                end
            end
            ST_FLUSH: begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_d[ptr_q][w]  = 1'b0;
                    ctr_d[ptr_q][w]    = '0;
                    target_d[ptr_q][w] = '0;
                    age_d[ptr_q][w]    = AGE_W'(w);
                end
                if (ptr_q == LAST_SET) state_d = ST_IDLE;
                else                   ptr_d   = ptr_q + IDX_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_upd) begin
            if (up_hit) begin
                target_d[up_idx][hit_way] = update_target;
                if (update_taken && ctr_q[up_idx][hit_way] != CTR_MAX)
                    ctr_d[up_idx][hit_way] = ctr_q[up_idx][hit_way] + CTR_W'(1);
                else if (!update_taken && ctr_q[up_idx][hit_way] != '0)
                    ctr_d[up_idx][hit_way] = ctr_q[up_idx][hit_way] - CTR_W'(1);
                do_touch  = 1'b1;
                touch_way = hit_way;
            end else if (update_taken || ALLOC_ON_NT != 0) begin
                touch_way = has_inv ? inv_way : lru_way;
                valid_d[up_idx][touch_way]  = 1'b1;
                tag_d[up_idx][touch_way]    = up_tag;
                target_d[up_idx][touch_way] = update_target;
                ctr_d[up_idx][touch_way]    = update_taken ? CTR_WT : CTR_WNT;
                do_touch = 1'b1;
            end
        end

        // move the touched way to MRU; only younger ways age by one
        if (do_touch) begin
            touch_age = age_q[up_idx][touch_way];
            for (int w = 0; w < WAYS; w++) begin
                if (AGE_W'(w) == touch_way)
                    age_d[up_idx][w] = '0;
                else if (age_q[up_idx][w] < touch_age)
                    age_d[up_idx][w] = age_q[up_idx][w] + AGE_W'(1);
            end
        end

        flush_busy_d = (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w]  <= 1'b0;
                    tag_q[s][w]    <= '0;
                    target_q[s][w] <= '0;
                    ctr_q[s][w]    <= '0;
                    age_q[s][w]    <= AGE_W'(w);
                end
            end
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            flush_busy_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            target_q     <= target_d;
            ctr_q        <= ctr_d;
            age_q        <= age_d;
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            flush_busy_q <= flush_busy_d;
        end
    end
endmodule

// File: tb/tb_btb_assoc_param.sv
// Self-checking bench for btb_assoc_param: directed vector table, flush and reset
// sequences, then random traffic against a recency-list reference model.
module tb_btb_assoc_param;
    localparam int NS = 8;
    localparam int NW = 2;
    localparam int IW = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lookup_pc = '0, update_pc = '0, update_target = '0;
    logic        update_valid = 1'b0, update_taken = 1'b0, flush_req = 1'b0;
    logic        lookup_hit, lookup_taken, flush_busy;
    logic [31:0] lookup_target;

    logic [31:0] n_lookup_pc = '0, n_update_pc = '0, n_update_target = '0;
    logic        n_update_valid = 1'b0, n_update_taken = 1'b0, n_flush_req = 1'b0;
    logic        n_hit, n_taken, n_busy;
    logic [31:0] n_target;

    int errors = 0;
    int checks = 0;

    btb_assoc_param #(.NUM_SETS(NS), .WAYS(NW), .CTR_W(2), .ALLOC_ON_NT(0)) dut (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .lookup_hit(lookup_hit),
        .lookup_taken(lookup_taken), .lookup_target(lookup_target),
        .update_valid(update_valid), .update_pc(update_pc), .update_target(update_target),
        .update_taken(update_taken), .flush_req(flush_req), .flush_busy(flush_busy));

    btb_assoc_param #(.NUM_SETS(NS), .WAYS(NW), .CTR_W(2), .ALLOC_ON_NT(1)) dut_nt (
        .clk(clk), .rst(rst), .lookup_pc(n_lookup_pc), .lookup_hit(n_hit),
        .lookup_taken(n_taken), .lookup_target(n_target),
        .update_valid(n_update_valid), .update_pc(n_update_pc), .update_target(n_update_target),
        .update_taken(n_update_taken), .flush_req(n_flush_req), .flush_busy(n_busy));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // reference model: per-set recency list, m_ord[s][0] is most recently used
    bit          m_valid [NS][NW];
    int unsigned m_tag   [NS][NW];
    logic [31:0] m_tgt   [NS][NW];
    int          m_ctr   [NS][NW];
    int          m_ord   [NS][NW];
    int          m_busy;

    function automatic int m_age(int s, int w);
        for (int k = 0; k < NW; k++) if (m_ord[s][k] == w) return k;
        return -1;
    endfunction

    task automatic m_clear_set(int s);
        for (int w = 0; w < NW; w++) begin
            m_valid[s][w] = 0; m_tag[s][w] = 0; m_tgt[s][w] = 0; m_ctr[s][w] = 0; m_ord[s][w] = w;
        end
    endtask

    task automatic m_reset();
        for (int s = 0; s < NS; s++) m_clear_set(s);
        m_busy = 0;
    endtask

    task automatic m_touch(int s, int w);
        int p;
        p = m_age(s, w);
        for (int k = p; k > 0; k--) m_ord[s][k] = m_ord[s][k-1];
        m_ord[s][0] = w;
    endtask

    task automatic m_edge(bit uv, logic [31:0] upc, logic [31:0] utgt, bit ut, bit fr);
        int s, h, v;
        int unsigned t;
        if (m_busy > 0) begin
            m_clear_set(NS - m_busy);
            m_busy--;
        end else if (fr) begin
            m_busy = NS;
        end else if (uv) begin
            s = (upc >> 2) % NS;
            t = upc >> (2 + IW);
            h = -1;
            for (int w = NW - 1; w >= 0; w--) if (m_valid[s][w] && m_tag[s][w] == t) h = w;
            if (h >= 0) begin
                m_tgt[s][h] = utgt;
                if (ut) m_ctr[s][h] = (m_ctr[s][h] == 3) ? 3 : m_ctr[s][h] + 1;
                else    m_ctr[s][h] = (m_ctr[s][h] == 0) ? 0 : m_ctr[s][h] - 1;
                m_touch(s, h);
            end else if (ut) begin
                v = m_ord[s][NW-1];
                for (int w = NW - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
                m_valid[s][v] = 1; m_tag[s][v] = t; m_tgt[s][v] = utgt; m_ctr[s][v] = 2;
                m_touch(s, v);
            end
        end
    endtask

    task automatic check_model(input string pfx);
        int s;
        int unsigned t;
        bit eh, et;
        logic [31:0] etg;
        eh = 0; et = 0; etg = 0;
        s = (lookup_pc >> 2) % NS;
        t = lookup_pc >> (2 + IW);
        if (m_busy == 0)
            for (int w = NW - 1; w >= 0; w--)
                if (m_valid[s][w] && m_tag[s][w] == t) begin
                    eh = 1; et = (m_ctr[s][w] >= 2); etg = m_tgt[s][w];
                end
        chk({pfx, "_hit"}, lookup_hit, eh);
        chk({pfx, "_taken"}, lookup_taken, et);
        chk({pfx, "_target"}, lookup_target, etg);
        chk({pfx, "_busy"}, flush_busy, m_busy > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge(update_valid, update_pc, update_target, update_taken, flush_req);
        #1;
    endtask

    // ages must always be a permutation of 0..NW-1
    always @(negedge clk) begin
        int seen;
        if (!rst) begin
            for (int s = 0; s < NS; s++) begin
                seen = 0;
                for (int w = 0; w < NW; w++) seen |= 1 << dut.age_q[s][w];
                if (seen != (1 << NW) - 1) chk("age_perm", seen, (1 << NW) - 1);
            end
            checks++;
        end
    end

    typedef struct {
        bit          uv;
        logic [31:0] upc;
        logic [31:0] utgt;
        bit          ut;
        logic [31:0] look;
        bit          eh;
        bit          et;
        logic [31:0] etg;
        bit          ckc;
        int          ectr;
    } vec_t;

    vec_t tv[13];

    initial begin
        int busy_cycles;
        bit bad;

        tv[0]  = '{1, 32'h100, 32'h200, 1, 32'h100, 1, 1, 32'h200, 1, 2};
        tv[1]  = '{1, 32'h100, 32'h200, 0, 32'h100, 1, 0, 32'h200, 1, 1};
        tv[2]  = '{1, 32'h100, 32'h200, 1, 32'h100, 1, 1, 32'h200, 1, 2};
        tv[3]  = '{1, 32'h100, 32'h200, 1, 32'h100, 1, 1, 32'h200, 1, 3};
        tv[4]  = '{1, 32'h100, 32'h200, 1, 32'h100, 1, 1, 32'h200, 1, 3};
        tv[5]  = '{1, 32'h100, 32'h200, 1, 32'h100, 1, 1, 32'h200, 1, 3};
        tv[6]  = '{1, 32'h120, 32'h300, 1, 32'h120, 1, 1, 32'h300, 0, 0};
        tv[7]  = '{1, 32'h100, 32'h204, 1, 32'h100, 1, 1, 32'h204, 1, 3};
        tv[8]  = '{1, 32'h140, 32'h400, 1, 32'h140, 1, 1, 32'h400, 0, 0};
        tv[9]  = '{0, 32'h0,   32'h0,   0, 32'h100, 1, 1, 32'h204, 1, 3};
        tv[10] = '{0, 32'h0,   32'h0,   0, 32'h120, 0, 0, 32'h0,   0, 0};
        tv[11] = '{1, 32'h180, 32'h500, 0, 32'h180, 0, 0, 32'h0,   0, 0};
        tv[12] = '{1, 32'h104, 32'h600, 0, 32'h104, 0, 0, 32'h0,   0, 0};

        m_reset();
        lookup_pc = 32'h100;
        #3;
        chk("reset_hit", lookup_hit, 0);
        chk("reset_taken", lookup_taken, 0);
        chk("reset_target", lookup_target, 0);
        chk("reset_busy", flush_busy, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tv[i]) begin
            update_valid = tv[i].uv; update_pc = tv[i].upc; update_target = tv[i].utgt;
            update_taken = tv[i].ut; lookup_pc = tv[i].look;
            tick();
            update_valid = 1'b0;
            #1;
            chk($sformatf("vec%0d_hit", i), lookup_hit, tv[i].eh);
            chk($sformatf("vec%0d_taken", i), lookup_taken, tv[i].et);
            chk($sformatf("vec%0d_target", i), lookup_target, tv[i].etg);
            if (tv[i].ckc) chk($sformatf("vec%0d_ctr", i), dut.ctr_q[(tv[i].look >> 2) % NS][0], tv[i].ectr);
        end
        chk("lru_age_w0", dut.age_q[0][0], 1);
        chk("lru_age_w1", dut.age_q[0][1], 0);

        // same-cycle update and lookup on an empty BTB
        rst = 1'b1; #1; m_reset(); rst = 1'b0;
        update_valid = 1'b1; update_pc = 32'h100; update_target = 32'h240; update_taken = 1'b1;
        lookup_pc = 32'h100;
        #1;
        chk("same_cyc_hit_before", lookup_hit, 0);
        tick();
        update_valid = 1'b0;
        chk("same_cyc_hit_after", lookup_hit, 1);
        chk("same_cyc_target_after", lookup_target, 32'h240);

        // allocate on not-taken miss
        n_update_valid = 1'b1; n_update_pc = 32'h180; n_update_target = 32'h500;
        n_update_taken = 1'b0; n_lookup_pc = 32'h180;
        tick();
        n_update_valid = 1'b0;
        chk("nt_alloc_hit", n_hit, 1);
        chk("nt_alloc_taken", n_taken, 0);
        chk("nt_alloc_target", n_target, 32'h500);
        chk("nt_alloc_ctr", dut_nt.ctr_q[0][0], 1);

        // asynchronous reset between clock edges
        #1; rst = 1'b1; #1;
        chk("async_rst_hit", lookup_hit, 0);
        chk("async_rst_target", lookup_target, 0);
        chk("async_rst_nt_hit", n_hit, 0);
        m_reset();
        #1; rst = 1'b0;

        // populate every set, then flush
        for (int s = 0; s < NS; s++) begin
            update_valid = 1'b1; update_pc = 32'h100 + 4 * s; update_target = 32'h800 + s;
            update_taken = 1'b1;
            tick();
        end
        update_valid = 1'b0; lookup_pc = 32'h10C;
        #1;
        check_model("prefill");
        flush_req = 1'b1; update_valid = 1'b1; update_pc = 32'h2000; update_target = 32'h44;
        tick();
        flush_req = 1'b0; update_valid = 1'b0; lookup_pc = 32'h100;
        busy_cycles = 0;
        for (int c = 0; c < 20; c++) begin
            if (!flush_busy) break;
            busy_cycles++;
            check_model($sformatf("flush%0d", c));
            update_valid = (c == 2); update_pc = 32'h3004; update_target = 32'h88;
            flush_req = (c == 4);
            tick();
            update_valid = 1'b0; flush_req = 1'b0;
        end
        chk("flush_busy_cycles", busy_cycles, NS);
        for (int s = 0; s < NS; s++) begin
            lookup_pc = 32'h100 + 4 * s; #1;
            chk($sformatf("post_flush_miss%0d", s), lookup_hit, 0);
            for (int w = 0; w < NW; w++) chk($sformatf("post_flush_age%0d_%0d", s, w), dut.age_q[s][w], w);
        end
        lookup_pc = 32'h2000; #1; chk("flush_dropped_upd", lookup_hit, 0);
        lookup_pc = 32'h3004; #1; chk("mid_flush_dropped_upd", lookup_hit, 0);

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            update_valid  = $urandom_range(0, 1);
            update_pc     = 32'h1000 + ($urandom_range(0, 3) << 5) + ($urandom_range(0, NS - 1) << 2);
            update_target = $urandom & 32'hFFFF_FFFC;
            update_taken  = $urandom_range(0, 1);
            flush_req     = ($urandom_range(0, 99) == 0);
            lookup_pc     = $urandom_range(0, 1) ? update_pc
                          : 32'h1000 + ($urandom_range(0, 3) << 5) + ($urandom_range(0, NS - 1) << 2);
            #1;
            check_model("rnd");
            bad = 0;
            for (int s = 0; s < NS; s++)
                for (int w = 0; w < NW; w++)
                    if (int'(dut.age_q[s][w]) != m_age(s, w)) bad = 1;
            chk("rnd_ages_match", bad, 0);
            tick();
        end
        update_valid = 1'b0; flush_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
